// File: rtl/tt6581_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tt6581_pkg : shared constants and FSM state type for the wave generator     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package tt6581_pkg;

  localparam int ACC_W  = 24;
  localparam int LFSR_W = 23;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 23'h7FFFFF;

  // Bit positions inside wave_sel_i
  localparam int WAVE_TRI   = 0;
  localparam int WAVE_SAW   = 1;
  localparam int WAVE_PULSE = 2;
  localparam int WAVE_NOISE = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/wave_gen_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wave_lfsr : per-voice noise shift register with seed load and 8-bit taps    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module wave_lfsr
  import tt6581_pkg::*;
#(
  parameter int LFSR_W = 23
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       i_shift,
  input  logic       i_load,
  output logic [7:0] o_noise
);

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_load) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_shift) begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], r_lfsr[22] ^ r_lfsr[17]};
    end
  end

  assign o_noise = {r_lfsr[22], r_lfsr[20], r_lfsr[16], r_lfsr[13],
                    r_lfsr[11], r_lfsr[7],  r_lfsr[4],  r_lfsr[2]};

endmodule
`default_nettype wire

// File: rtl/wave_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wave_gen : time-multiplexed 3-voice oscillator / raw waveform generator     |
// | Optional macro WAVE_RING_MOD_EN enables triangle ring modulation.           |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module wave_gen
  import tt6581_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int ACC_W      = 24,
  parameter int LFSR_W     = 23
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  voice_idx_i,
  input  logic [15:0] freq_i,
  input  logic [11:0] pw_i,
  input  logic [3:0]  wave_sel_i,
  input  logic        test_i,
  input  logic        ring_i,
  output logic        ready_o,
  output logic [9:0]  wave_o
);

  state_e r_state, w_next;
  logic   w_ready;
  logic   w_calc;

  logic [ACC_W-1:0] r_acc [NUM_VOICES];
  logic [9:0]       r_wave;

  logic [NUM_VOICES-1:0] w_hit;
  logic [NUM_VOICES-1:0] w_shift;
  logic [NUM_VOICES-1:0] w_load;
  logic [7:0]            w_noise_v [NUM_VOICES];

  logic             w_valid;
  logic [ACC_W-1:0] w_acc_old;
  logic [ACC_W-1:0] w_acc_new;
  logic [7:0]       w_noise;
  logic             w_fold;
  logic [9:0]       w_saw, w_tri, w_pulse, w_noise_wave;
  logic [9:0]       w_mix, w_sample;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      IDLE: if (start_i) w_next = CALC;
      CALC: w_next = DONE;
      DONE: begin
        w_next  = IDLE;
        w_ready = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_calc = (r_state == CALC);

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      assign w_hit[gi]   = (voice_idx_i == 2'(gi));
      assign w_load[gi]  = w_calc & w_hit[gi] & test_i;
      // Noise clocks on the rising edge of accumulator bit 19.
      assign w_shift[gi] = w_calc & w_hit[gi] & ~test_i & ~w_acc_old[19] & w_acc_new[19];

      wave_lfsr #(
        .LFSR_W (LFSR_W)
      ) u_lfsr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_shift (w_shift[gi]),
        .i_load  (w_load[gi]),
        .o_noise (w_noise_v[gi])
      );
    end
  endgenerate

  assign w_valid   = |w_hit;
  assign w_acc_new = w_acc_old + {{(ACC_W-16){1'b0}}, freq_i};

`ifdef WAVE_RING_MOD_EN
  logic w_mod_msb;

  always_comb begin
    w_acc_old = '0;
    w_noise   = '0;
    w_mod_msb = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (w_hit[i]) begin
        w_acc_old = r_acc[i];
        w_noise   = w_noise_v[i];
        // Each voice is modulated by its predecessor (0<-2, 1<-0, 2<-1).
        w_mod_msb = r_acc[(i + NUM_VOICES - 1) % NUM_VOICES][ACC_W-1];
      end
    end
  end

  assign w_fold = w_acc_old[ACC_W-1] ^ (ring_i & w_mod_msb);
`else
  logic w_unused_ring;

  always_comb begin
    w_acc_old = '0;
    w_noise   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (w_hit[i]) begin
        w_acc_old = r_acc[i];
        w_noise   = w_noise_v[i];
      end
    end
  end

  assign w_unused_ring = ring_i;
  assign w_fold        = w_acc_old[ACC_W-1];
`endif

  assign w_saw        = w_acc_old[ACC_W-1 -: 10];
  assign w_tri        = w_fold ? ~w_acc_old[ACC_W-2 -: 10] : w_acc_old[ACC_W-2 -: 10];
  assign w_pulse      = (w_acc_old[ACC_W-1 -: 12] >= pw_i) ? 10'h3FF : 10'h000;
  assign w_noise_wave = {w_noise, 2'b00};

  always_comb begin
    w_mix = 10'h3FF;
    if (wave_sel_i[WAVE_TRI])   w_mix = w_mix & w_tri;
    if (wave_sel_i[WAVE_SAW])   w_mix = w_mix & w_saw;
    if (wave_sel_i[WAVE_PULSE]) w_mix = w_mix & w_pulse;
    if (wave_sel_i[WAVE_NOISE]) w_mix = w_mix & w_noise_wave;
    if (wave_sel_i == 4'h0)     w_mix = 10'h000;

    w_sample = w_mix;
    if (test_i)   w_sample = wave_sel_i[WAVE_PULSE] ? 10'h3FF : 10'h000;
    if (!w_valid) w_sample = 10'h000;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_VOICES; i++) r_acc[i] <= '0;
      r_wave <= '0;
    end else if (w_calc) begin
      r_wave <= w_sample;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (w_hit[i]) r_acc[i] <= test_i ? '0 : w_acc_new;
      end
    end
  end

  assign ready_o = w_ready;
  assign wave_o  = r_wave;

endmodule
`default_nettype wire

// File: tb/tb_wave_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wave_gen : scoreboard bench for wave_gen (directed vectors)              |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_wave_gen;
  import tt6581_pkg::*;

  logic        clk_i       = 1'b0;
  logic        rst_ni      = 1'b0;
  logic        start_i     = 1'b0;
  logic [1:0]  voice_idx_i = 2'd0;
  logic [15:0] freq_i      = 16'h0;
  logic [11:0] pw_i        = 12'h0;
  logic [3:0]  wave_sel_i  = 4'h0;
  logic        test_i      = 1'b0;
  logic        ring_i      = 1'b0;
  logic        ready_o;
  logic [9:0]  wave_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [9:0]  exp_q [$];
  int          t_q   [$];
  logic [23:0] sh_acc  [3];
  logic [22:0] sh_lfsr [3];

`ifdef WAVE_RING_MOD_EN
  localparam logic [9:0] RING_EXP = 10'h37F;
`else
  localparam logic [9:0] RING_EXP = 10'h080;
`endif

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  wave_gen u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .voice_idx_i (voice_idx_i),
    .freq_i      (freq_i),
    .pw_i        (pw_i),
    .wave_sel_i  (wave_sel_i),
    .test_i      (test_i),
    .ring_i      (ring_i),
    .ready_o     (ready_o),
    .wave_o      (wave_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every ready pulse pops one expected sample and its issue cycle.
  initial begin
    logic [9:0] e;
    int         t;
    forever begin
      @(negedge clk_i);
      if (rst_ni === 1'b1 && ready_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_ready: actual ready with wave %h required no ready", wave_o);
        end else begin
          e = exp_q.pop_front();
          t = t_q.pop_front();
          check("wave", 32'(wave_o), 32'(e));
          check("latency", 32'(cyc - t), 32'd2);
        end
      end
    end
  end

  task automatic model_step(input logic [1:0] v, input logic [15:0] f, input logic [11:0] pw,
                            input logic [3:0] sel, input logic tst, output logic [9:0] e);
    logic [23:0] a, na;
    logic [22:0] l;
    logic [9:0]  tri_w, noi;
    int          vi;
    e  = 10'h000;
    vi = int'(v);
    if (vi < 3) begin
      a = sh_acc[vi];
      l = sh_lfsr[vi];
      if (tst) begin
        sh_acc[vi]  = 24'h0;
        sh_lfsr[vi] = LFSR_SEED;
        e = sel[2] ? 10'h3FF : 10'h000;
      end else begin
        tri_w = a[23] ? ~a[22:13] : a[22:13];
        noi   = {l[22], l[20], l[16], l[13], l[11], l[7], l[4], l[2], 2'b00};
        if (sel != 4'h0) begin
          e = 10'h3FF;
          if (sel[0]) e = e & tri_w;
          if (sel[1]) e = e & a[23:14];
          if (sel[2]) e = e & ((a[23:12] >= pw) ? 10'h3FF : 10'h000);
          if (sel[3]) e = e & noi;
        end
        na = a + {8'h00, f};
        if (!a[19] && na[19]) l = {l[21:0], l[22] ^ l[17]};
        sh_acc[vi]  = na;
        sh_lfsr[vi] = l;
      end
    end
  endtask

  task automatic issue(input logic [1:0] v, input logic [15:0] f, input logic [11:0] pw,
                       input logic [3:0] sel, input logic tst, input logic rg,
                       input bit glitch, input bit use_exp, input logic [9:0] exp_v);
    logic [9:0] e;
    model_step(v, f, pw, sel, tst, e);
    if (use_exp) e = exp_v;
    @(negedge clk_i);
    voice_idx_i = v;
    freq_i      = f;
    pw_i        = pw;
    wave_sel_i  = sel;
    test_i      = tst;
    ring_i      = rg;
    start_i     = 1'b1;
    exp_q.push_back(e);
    t_q.push_back(cyc);
    @(negedge clk_i);
    start_i = glitch;
    @(negedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] t1_exp [8];
    logic [9:0] t3_exp [6];
    t1_exp = '{10'h0, 10'h0, 10'h0, 10'h0, 10'h1, 10'h1, 10'h1, 10'h1};
    t3_exp = '{10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF, 10'h3FF, 10'h3FE};
    for (int i = 0; i < 3; i++) begin
      sh_acc[i]  = 24'h0;
      sh_lfsr[i] = LFSR_SEED;
    end

    repeat (3) @(negedge clk_i);
    check("reset_ready", 32'(ready_o), 32'd0);
    check("reset_wave", 32'(wave_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Reset during CALC drops the pending ready and leaves state untouched.
    voice_idx_i = 2'd0;
    freq_i      = 16'h1000;
    wave_sel_i  = 4'b0010;
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    rst_ni  = 1'b0;
    #1;
    check("midrst_ready_calc", 32'(ready_o), 32'd0);
    @(negedge clk_i);
    check("midrst_ready_done", 32'(ready_o), 32'd0);
    check("midrst_wave", 32'(wave_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int k = 0; k < 8; k++)
      issue(2'd0, 16'h1000, 12'h000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, t1_exp[k]);

    for (int k = 0; k < 260; k++)
      issue(2'd1, 16'hFFFF, 12'h800, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);

    issue(2'd2, 16'h8000, 12'h000, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000);
    for (int k = 0; k < 255; k++)
      issue(2'd2, 16'h8000, 12'h000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    for (int k = 0; k < 6; k++)
      issue(2'd2, 16'h2000, 12'h000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, t3_exp[k]);

    issue(2'd0, 16'h1000, 12'h000, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000);
    for (int k = 0; k < 641; k++) begin
      if (k == 0)        issue(2'd0, 16'h1000, 12'h000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h3FC);
      else if (k == 640) issue(2'd0, 16'h1000, 12'h000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h3F8);
      else               issue(2'd0, 16'h1000, 12'h000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    end

    for (int i = 0; i < 18; i++) begin
      logic [15:0] f;
      logic [1:0]  v;
      v = 2'(i % 3);
      f = (v == 2'd0) ? 16'h1234 : (v == 2'd1) ? 16'h0F0F : 16'h4321;
      issue(v, f, 12'h400, 4'((i * 7 + 3) % 16), (i == 7), 1'b0, i[0], 1'b0, 10'h0);
      if (i == 9) issue(2'd3, 16'h5555, 12'h000, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 10'h000);
    end

    issue(2'd0, 16'h0, 12'h000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000);
    issue(2'd2, 16'h0, 12'h000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000);
    for (int k = 0; k < 129; k++)
      issue(2'd2, 16'hFFFF, 12'h000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    for (int k = 0; k < 32; k++)
      issue(2'd0, 16'h8000, 12'h000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);
    issue(2'd0, 16'h0000, 12'h000, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, RING_EXP);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_i);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: actual %0d pending required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
